// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  localparam logic [1:0] SEL_NONE   = 2'b00;
  localparam logic [1:0] SEL_BRANCH = 2'b01;
  localparam logic [1:0] SEL_JUMP   = 2'b10;
  localparam logic [1:0] SEL_JREG   = 2'b11;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_target_sel.sv
// Picks the redirect target from the select code and word-aligns it.
module fetch_target_sel
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              redirect_valid,
  input  logic [1:0]        redirect_sel,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic [ADDR_W-1:0] jreg_target,
  output logic              take,
  output logic [ADDR_W-1:0] target
);

  logic [ADDR_W-1:0] raw;

  always_comb begin
    raw = branch_target;
    case (redirect_sel)
      SEL_JUMP: raw = jump_target;
      SEL_JREG: raw = jreg_target;
      default:  raw = branch_target;
    endcase
    target = {raw[ADDR_W-1:2], 2'b00};
    take   = redirect_valid && (redirect_sel != SEL_NONE);
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, drives the imem req/ready
// handshake and presents a registered instr/PC+4 pair to decode.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [1:0]        redirect_sel,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic [ADDR_W-1:0] jreg_target,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc_plus4,
  output logic              flush
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] disc_addr_q, disc_addr_d;
  logic              if_valid_q, if_valid_d;
  logic [31:0]       if_instr_q, if_instr_d;
  logic [ADDR_W-1:0] if_pc_plus4_q, if_pc_plus4_d;
  logic              flush_q, flush_d;

  logic              take;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc_plus4;
  logic              can_accept;
  logic              handshake;

  fetch_target_sel #(.ADDR_W(ADDR_W)) u_target_sel (
    .redirect_valid (redirect_valid),
    .redirect_sel   (redirect_sel),
    .branch_target  (branch_target),
    .jump_target    (jump_target),
    .jreg_target    (jreg_target),
    .take           (take),
    .target         (target)
  );

  assign pc_plus4   = pc_q + ADDR_W'(4);
  assign can_accept = !if_valid_q || !stall;
  assign handshake  = mem_req && mem_ready;

  always_comb begin
    mem_req  = 1'b0;
    mem_addr = pc_q;
    case (state_q)
      FETCH:   mem_req = can_accept;
      DISCARD: begin
        mem_req  = 1'b1;
        mem_addr = disc_addr_q;
      end
      default: mem_req = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    disc_addr_d   = disc_addr_q;
    if_valid_d    = if_valid_q;
    if_instr_d    = if_instr_q;
    if_pc_plus4_d = if_pc_plus4_q;
    flush_d       = 1'b0;

    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH: begin
        // An open request the memory has not yet accepted must still be
        // drained at its original address before the new PC is requested.
        if (take && mem_req && !mem_ready) begin
          state_d     = DISCARD;
          disc_addr_d = pc_q;
        end
      end
      DISCARD: if (mem_ready) state_d = FETCH;
      default: state_d = IDLE;
    endcase

    if (take) begin
      pc_d       = target;
      if_valid_d = 1'b0;
      flush_d    = 1'b1;
    end else if (state_q == FETCH && handshake) begin
      if_instr_d    = mem_rdata;
      if_pc_plus4_d = pc_plus4;
      if_valid_d    = 1'b1;
      pc_d          = pc_plus4;
    end else if (!stall) begin
      if_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      disc_addr_q   <= RESET_PC;
      if_valid_q    <= 1'b0;
      if_instr_q    <= '0;
      if_pc_plus4_q <= '0;
      flush_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      disc_addr_q   <= disc_addr_d;
      if_valid_q    <= if_valid_d;
      if_instr_q    <= if_instr_d;
      if_pc_plus4_q <= if_pc_plus4_d;
      flush_q       <= flush_d;
    end
  end

  assign if_valid    = if_valid_q;
  assign if_instr    = if_instr_q;
  assign if_pc_plus4 = if_pc_plus4_q;
  assign flush       = flush_q;

endmodule
